// File: rtl/n64a_vdemux.sv
// N64 video bus demultiplexer: locks to nDSYNC, gathers sync/R/G/B of each
// 4-cycle pixel slot into one widened parallel word with a valid strobe.
module n64a_vdemux #(
    parameter int color_width_i = 7,
    parameter int color_width_o = 8,
    parameter bit lsb_ext       = 1'b1
) (
    input  logic                           VCLK,
    input  logic                           nRST,
    input  logic                           nDSYNC,
    input  logic [color_width_i-1:0]       D_i,
    output logic [3*color_width_o+3:0]     vdata_o,
    output logic                           vdata_valid_o,
    output logic                           locked_o,
    output logic [7:0]                     slip_cnt_o
);

    typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

    state_t                       r_state;
    logic                         r_dsync_n;
    logic [color_width_i-1:0]     r_d;
    logic [1:0]                   r_phase;
    logic [3:0]                   r_s_cap;
    logic [color_width_i-1:0]     r_r_cap;
    logic [color_width_i-1:0]     r_g_cap;
    logic [color_width_i-1:0]     r_b_cap;
    logic [3*color_width_o+3:0]   r_vdata;
    logic                         r_valid;
    logic                         r_locked;
    logic [7:0]                   r_slip;
    logic                         w_slip;

    // Left-justify the colour and fill the vacated LSBs with its MSB or zero.
    function automatic logic [color_width_o-1:0] widen(input logic [color_width_i-1:0] c);
        logic                                   fill;
        logic [color_width_i+color_width_o-1:0] t;
        fill = lsb_ext ? c[color_width_i-1] : 1'b0;
        t    = {c, {color_width_o{fill}}} >> color_width_i;
        return t[color_width_o-1:0];
    endfunction

    // Slip: marker missing after B, or marker arriving mid-slot.
    always_comb begin
        w_slip = 1'b0;
        if (r_state == ST_LOCKED)
            w_slip = (r_phase == 2'd0) ? r_dsync_n : !r_dsync_n;
    end

    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            r_state   <= ST_UNLOCKED;
            r_dsync_n <= 1'b1;
            r_d       <= '0;
            r_phase   <= '0;
            r_s_cap   <= '0;
            r_r_cap   <= '0;
            r_g_cap   <= '0;
            r_b_cap   <= '0;
            r_vdata   <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_slip    <= '0;
        end else begin
            r_dsync_n <= nDSYNC;
            r_d       <= D_i;
            r_valid   <= 1'b0;

            if (!r_dsync_n) begin
                r_phase <= 2'd1;
                r_s_cap <= r_d[3:0];
            end else begin
                r_phase <= r_phase + 2'd1;
                case (r_phase)
                    2'd1:    r_r_cap <= r_d;
                    2'd2:    r_g_cap <= r_d;
                    2'd3:    r_b_cap <= r_d;
                    default: ;
                endcase
            end

            if (w_slip && r_slip != 8'hFF)
                r_slip <= r_slip + 8'd1;

            if (r_state == ST_UNLOCKED) begin
                if (!r_dsync_n) begin
                    r_state  <= ST_LOCKED;
                    r_locked <= 1'b1;
                end
            end else if (r_phase == 2'd0) begin
                if (!r_dsync_n) begin
                    // The next marker overwrites S_cap on this same edge; the
                    // commit reads the completed slot's S before the update.
                    r_vdata <= {r_s_cap, widen(r_r_cap), widen(r_g_cap), widen(r_b_cap)};
                    r_valid <= 1'b1;
                end else begin
                    r_state  <= ST_UNLOCKED;
                    r_locked <= 1'b0;
                end
            end
        end
    end

    assign vdata_o       = r_vdata;
    assign vdata_valid_o = r_valid;
    assign locked_o      = r_locked;
    assign slip_cnt_o    = r_slip;

endmodule

// File: tb/tb_n64a_vdemux.sv
// Directed bench for n64a_vdemux: two instances (MSB fill / zero fill) share
// the same N64 bus stimulus; expected words are hand-computed constants.
module tb_n64a_vdemux;

    logic        VCLK = 1'b0;
    logic        nRST;
    logic        nDSYNC;
    logic [6:0]  D_i;

    logic [27:0] vd1, vd0;
    logic        vv1, vv0, lk1, lk0;
    logic [7:0]  sc1, sc0;

    int          tests = 0;
    int          fails = 0;
    int          nval  = 0;
    int          n0;
    logic [27:0] lw1 = '0;
    logic [27:0] lw0 = '0;

    always #5 VCLK = ~VCLK;

    n64a_vdemux #(.color_width_i(7), .color_width_o(8), .lsb_ext(1'b1)) u_dut (
        .VCLK(VCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D_i),
        .vdata_o(vd1), .vdata_valid_o(vv1), .locked_o(lk1), .slip_cnt_o(sc1)
    );

    n64a_vdemux #(.color_width_i(7), .color_width_o(8), .lsb_ext(1'b0)) u_dut_zf (
        .VCLK(VCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D_i),
        .vdata_o(vd0), .vdata_valid_o(vv0), .locked_o(lk0), .slip_cnt_o(sc0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one bus word at the falling edge; record any committed word.
    task automatic drv(input logic ds, input logic [6:0] d);
        @(negedge VCLK);
        nDSYNC = ds;
        D_i    = d;
        #1;
        if (vv1) begin
            nval++;
            lw1 = vd1;
            lw0 = vd0;
        end
    endtask

    // One pixel slot; D[6:4] of the sync word carries junk that must be ignored.
    task automatic slot(input logic mk, input logic [3:0] s, input logic [6:0] r,
                        input logic [6:0] g, input logic [6:0] b);
        drv(!mk, {3'b111, s});
        drv(1'b1, r);
        drv(1'b1, g);
        drv(1'b1, b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        nRST   = 1'b0;
        nDSYNC = 1'b1;
        D_i    = '0;
        repeat (3) drv(1'b1, 7'h00);
        check("rst_vdata",  32'(vd1), 32'h0);
        check("rst_vdata0", 32'(vd0), 32'h0);
        check("rst_valid",  32'(vv1), 32'h0);
        check("rst_lock",   32'(lk1), 32'h0);
        check("rst_slip",   32'(sc1), 32'h0);
        nRST = 1'b1;

        // Clean stream: lock timing, latency and per-slot strobe
        drv(1'b0, 7'h7B);
        drv(1'b1, 7'h7F);
        check("lock_pre", 32'(lk1), 32'h0);
        drv(1'b1, 7'h00);
        check("lock", 32'(lk1), 32'h1);
        drv(1'b1, 7'h40);
        drv(1'b0, 7'h7B);
        drv(1'b1, 7'h7F);
        check("lat_r", 32'(vv1), 32'h0);
        drv(1'b1, 7'h00);
        check("lat_g", 32'(vv1), 32'h1);
        check("word_ext",  32'(vd1), 32'h0BFF0081);
        check("word_zero", 32'(vd0), 32'h0BFE0080);
        drv(1'b1, 7'h40);
        check("pulse", 32'(vv1), 32'h0);
        n0 = nval;
        slot(1'b1, 4'hB, 7'h7F, 7'h00, 7'h40);
        slot(1'b1, 4'hB, 7'h7F, 7'h00, 7'h40);
        check("rate",  32'(nval - n0), 32'd2);
        check("slip0", 32'(sc1), 32'h0);

        // Missing marker: unlock, drop, relock on next marker
        n0 = nval;
        slot(1'b0, 4'hB, 7'h7F, 7'h00, 7'h40);
        check("miss_nv",   32'(nval - n0), 32'd0);
        check("miss_lock", 32'(lk1), 32'h0);
        check("miss_slip", 32'(sc1), 32'h1);
        slot(1'b1, 4'h5, 7'h41, 7'h02, 7'h7E);
        slot(1'b1, 4'hB, 7'h7F, 7'h00, 7'h40);
        check("relock_nv",   32'(nval - n0), 32'd1);
        check("relock_ext",  32'(lw1), 32'h058304FD);
        check("relock_zero", 32'(lw0), 32'h058204FC);
        check("relock_lock", 32'(lk1), 32'h1);
        check("relock_slip", 32'(sc1), 32'h1);

        // Early marker at the G position: restart with new S, lock held
        n0 = nval;
        drv(1'b0, 7'h03);
        drv(1'b1, 7'h11);
        drv(1'b0, 7'h0C);
        drv(1'b1, 7'h22);
        drv(1'b1, 7'h33);
        drv(1'b1, 7'h44);
        check("early_lock", 32'(lk1), 32'h1);
        check("early_slip", 32'(sc1), 32'h2);
        slot(1'b1, 4'hB, 7'h7F, 7'h00, 7'h40);
        check("early_nv",   32'(nval - n0), 32'd2);
        check("early_ext",  32'(lw1), 32'h0C446689);
        check("early_zero", 32'(lw0), 32'h0C446688);

        // One-cycle reset after R captured
        drv(1'b0, 7'h7B);
        drv(1'b1, 7'h7F);
        drv(1'b1, 7'h00);
        drv(1'b1, 7'h40);
        nRST = 1'b0;
        drv(1'b1, 7'h00);
        check("mid_vdata",  32'(vd1), 32'h0);
        check("mid_vdata0", 32'(vd0), 32'h0);
        check("mid_valid",  32'(vv1), 32'h0);
        check("mid_lock",   32'(lk1), 32'h0);
        check("mid_slip",   32'(sc1), 32'h0);
        nRST = 1'b1;
        n0 = nval;
        drv(1'b1, 7'h7F);
        drv(1'b1, 7'h00);
        drv(1'b1, 7'h40);
        drv(1'b1, 7'h00);
        check("post_nv",   32'(nval - n0), 32'd0);
        check("post_lock", 32'(lk1), 32'h0);
        slot(1'b1, 4'h6, 7'h01, 7'h7F, 7'h00);
        slot(1'b1, 4'hB, 7'h7F, 7'h00, 7'h40);
        check("fresh_nv",   32'(nval - n0), 32'd1);
        check("fresh_ext",  32'(lw1), 32'h0602FF00);
        check("fresh_zero", 32'(lw0), 32'h0602FE00);

        // Marker held low: one slip per cycle, counter saturates
        n0 = nval;
        repeat (100) drv(1'b0, 7'h0F);
        check("slip_mid", 32'(sc1), 32'd97);
        repeat (300) drv(1'b0, 7'h0F);
        check("slip_sat",  32'(sc1), 32'hFF);
        check("slip_sat0", 32'(sc0), 32'hFF);
        check("storm_lock", 32'(lk1), 32'h1);
        check("storm_nv",  32'(nval - n0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
